pipelined_adder: RTL and testbench
==================================

// Module: pipelined_adder
// PURPOSE
//   Segmented, pipelined add/subtract unit; next-generation datapath adder for the OoO core's ALU/AGU.
//   Splits the BIT_WIDTH carry chain into STAGES equal segments. Each segment resolves one pipeline
//   stage, so throughput is one op/cycle at SEG_W-bit critical path. Valid/ready handshake on both
//   sides, with full-pipeline backpressure.
// PARAMETERS
//   BIT_WIDTH  64  operand/sum width; must be divisible by STAGES (elaboration $error otherwise)
//   STAGES     4   pipeline stages = carry segments; 1 <= STAGES <= BIT_WIDTH
//   SEG_W      BIT_WIDTH/STAGES  derived localparam, bits resolved per stage
// PORTS
//   clk       in   1          clock, all state on rising edge
//   rstN      in   1          asynchronous, active-low reset
//   inValid   in   1          operand bundle valid
//   inReady   out  1          unit can accept bundle this cycle
//   in1       in   BIT_WIDTH  first operand
//   in2       in   BIT_WIDTH  second operand
//   cIn       in   1          carry in (ignored when sub=1)
//   sub       in   1          0: in1+in2+cIn; 1: in1+~in2+1 (in1-in2)
//   outValid  out  1          result valid
//   outReady  in   1          consumer accepts result
//   sum       out  BIT_WIDTH  result
//   cOut      out  1          carry out of MSB (sub: 1 = no borrow)
//   ovf       out  1          signed overflow        [ADDER_PIPE_FLAGS_EN only]
//   zero      out  1          sum == 0               [ADDER_PIPE_FLAGS_EN only]
// BEHAVIOUR
//   - Reset (rstN=0, async): all stage valid bits, sum, cOut, ovf, zero -> 0. inReady = 1 once
//     released; in-flight ops are discarded.
//   - Global advance: adv = !outValid || outReady. inReady = adv (combinational). Accept = inValid && adv.
//   - When adv=0 every stage register (data, carry, valid) holds; outputs held stable.
//   - Stage k (0..STAGES-1) adds segment k of in1/in2' plus carry register from stage k-1.
//     Stage 0 uses cinEff = sub ? 1 : cIn, and in2' = sub ? ~in2 : in2.
//   - Unresolved upper operand segments are skewed forward; resolved lower sum segments are
//     deskewed forward, so sum appears whole.
//   - Latency: exactly STAGES cycles from accept edge to outValid=1 (STAGES=1 -> registered adder).
//   - Throughput: 1 op/cycle when outReady=1. Results leave in issue order; bubbles
//     (inValid=0) propagate as valid=0 slots.
//   - Arithmetic is modulo 2^BIT_WIDTH. cOut = carry out of bit BIT_WIDTH-1 of the full
//     BIT_WIDTH+1 sum, identical to an unpipelined in1+in2'+cinEff.
//   - Simultaneous accept and output-drain in one cycle: both occur, no slot lost.
//   - Backpressure while the pipe is not full: whole pipe stalls anyway (no bubble collapse) -- decided,
//     keeps control to one enable.
// CONFIGURATION
//   `define ADDER_PIPE_FLAGS_EN
//     - Defined: ovf = (a[MSB]==b'[MSB]) && (sum[MSB]!=a[MSB]), computed in the last stage.
//     - Defined: zero = ~|sum, registered with sum and valid with outValid.
//     - Defined: both flags reset to 0.
//   - Not defined: ovf/zero ports and their logic are absent; all other behaviour is identical.
// TESTING (BIT_WIDTH=16, STAGES=4)
//   1. rstN=0 -> outValid=0, sum=0, cOut=0; release -> inReady=1.
//   2. 0xFFFF+0x0001, cIn=0, sub=0 -> 4 cycles later outValid=1, sum=0x0000, cOut=1
//      (carry crosses all segments).
//   3. sub=1, 0x0005-0x0007 -> sum=0xFFFE, cOut=0; FLAGS_EN: ovf=0, zero=0.
//      0x1234-0x1234 -> sum=0, cOut=1, zero=1.
//   4. Stream 0x0001+0x0001, 0x00FF+0x0001, 0x0FFF+0x0001, 0x7FFF+0x0001 back-to-back, outReady=1
//      -> consecutive outputs 0x0002, 0x0100, 0x1000, 0x8000. FLAGS_EN: last has ovf=1.
//   5. Result pending, outReady=0 for 3 cycles -> inReady=0, sum/cOut stable. On outReady=1,
//      queued results drain in order with none lost or duplicated.
//   6. Assert rstN=0 with 3 ops in flight -> outValid=0 immediately. None of the 3 results
//      ever appears after release.

Source files
------------

// File: rtl/pipelined_adder.sv
// -----------------------------------------------------------------------------
// pipelined_adder
//   Segmented, pipelined add/subtract unit. The BIT_WIDTH carry chain is cut
//   into STAGES equal segments of SEG_W bits. Pipeline stage k resolves segment
//   k using the carry registered by stage k-1. Each op therefore needs exactly
//   STAGES cycles from its accept edge to its result, and the unit sustains one
//   op per cycle.
//
//   Operands ride forward with their op: stage k still needs the upper operand
//   segments. Partial sums ride forward as well: the segments resolved so far
//   are carried along, so the whole sum appears at the output together.
//
//   All stages share one enable, adv = !outValid || outReady. When the output
//   is blocked the whole pipe freezes, including empty slots, so bubbles are
//   never collapsed.
//
// Parameters
//   BIT_WIDTH : operand/sum width. Must be a multiple of STAGES.
//   STAGES    : number of pipeline stages = carry segments (1..BIT_WIDTH).
//
// Ports
//   clk       : clock. All state changes on the rising edge.
//   rstN      : asynchronous, active-low reset. It clears every stage.
//   inValid   : an operand bundle is present.
//   inReady   : the unit accepts a bundle this cycle (combinational = adv).
//   in1, in2  : operands.
//   cIn       : carry in for add. It is ignored when sub=1.
//   sub       : 0 -> in1+in2+cIn, 1 -> in1+~in2+1 (in1-in2).
//   outValid  : a result is present (registered).
//   outReady  : the consumer takes the result.
//   sum       : result, modulo 2^BIT_WIDTH (registered).
//   cOut      : carry out of the MSB. For sub, 1 means no borrow (registered).
//   ovf       : signed overflow. Present only with ADDER_PIPE_FLAGS_EN.
//   zero      : sum == 0. Present only with ADDER_PIPE_FLAGS_EN.
//
// Configuration macro
//   ADDER_PIPE_FLAGS_EN : when defined, adds the ovf/zero flag ports and their
//                         last-stage logic.
// -----------------------------------------------------------------------------
module pipelined_adder #(
  parameter int BIT_WIDTH = 64,
  parameter int STAGES    = 4
) (
  input  logic                 clk,
  input  logic                 rstN,
  input  logic                 inValid,
  output logic                 inReady,
  input  logic [BIT_WIDTH-1:0] in1,
  input  logic [BIT_WIDTH-1:0] in2,
  input  logic                 cIn,
  input  logic                 sub,
  output logic                 outValid,
  input  logic                 outReady,
  output logic [BIT_WIDTH-1:0] sum,
  output logic                 cOut
`ifdef ADDER_PIPE_FLAGS_EN
  ,
  output logic                 ovf,
  output logic                 zero
`endif
);

  localparam int SEG_W = BIT_WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;
  localparam int MSB   = BIT_WIDTH - 1;

  // Reject configurations whose segments would not tile the word exactly.
  if ((STAGES < 1) || (STAGES > BIT_WIDTH) || ((BIT_WIDTH % STAGES) != 0)) begin : g_bad_cfg
    $error("pipelined_adder: BIT_WIDTH must be a multiple of STAGES, 1 <= STAGES <= BIT_WIDTH");
  end

  // Adds one segment plus carry. The MSB of the result is the segment carry out.
  function automatic logic [SEG_W:0] seg_add(
    input logic [SEG_W-1:0] a,
    input logic [SEG_W-1:0] b,
    input logic             c
  );
    seg_add = {1'b0, a} + {1'b0, b} + {{SEG_W{1'b0}}, c};
  endfunction

  // Handshake
  logic                 adv_s;
  logic                 accept_s;

  // Per-stage combinational inputs: the issue port for stage 0, the previous
  // stage's registers for every later stage.
  logic [BIT_WIDTH-1:0] src_a_s   [STAGES];
  logic [BIT_WIDTH-1:0] src_b_s   [STAGES];
  logic [BIT_WIDTH-1:0] src_sum_s [STAGES];
  logic [STAGES-1:0]    src_c_s;
  logic [STAGES-1:0]    src_v_s;

  // Per-stage combinational results
  logic [SEG_W:0]       seg_res_s [STAGES];
  logic [BIT_WIDTH-1:0] nxt_sum_s [STAGES];
  logic [STAGES-1:0]    nxt_c_s;

  // Stage registers
  logic [BIT_WIDTH-1:0] a_r       [STAGES];
  logic [BIT_WIDTH-1:0] b_r       [STAGES];
  logic [BIT_WIDTH-1:0] sum_r     [STAGES];
  logic [STAGES-1:0]    carry_r;
  logic [STAGES-1:0]    valid_r;

  // The pipe moves only when the output slot is empty or being drained.
  always_comb begin
    adv_s    = (~valid_r[LAST]) | outReady;
    accept_s = inValid & adv_s;
  end

  // Source selection for each stage.
  // Stage 0 applies the subtract transform: invert in2 and force carry-in to 1.
  always_comb begin
    src_a_s[0]   = in1;
    src_b_s[0]   = sub ? ~in2 : in2;
    src_sum_s[0] = {BIT_WIDTH{1'b0}};
    src_c_s[0]   = sub ? 1'b1 : cIn;
    src_v_s[0]   = accept_s;
    for (int k = 1; k < STAGES; k++) begin
      src_a_s[k]   = a_r[k-1];
      src_b_s[k]   = b_r[k-1];
      src_sum_s[k] = sum_r[k-1];
      src_c_s[k]   = carry_r[k-1];
      src_v_s[k]   = valid_r[k-1];
    end
  end

  // Stage k resolves segment k and merges it into the partial sum carried along.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      seg_res_s[k] = seg_add(src_a_s[k][k*SEG_W +: SEG_W],
                             src_b_s[k][k*SEG_W +: SEG_W],
                             src_c_s[k]);
      nxt_sum_s[k] = src_sum_s[k];
      nxt_sum_s[k][k*SEG_W +: SEG_W] = seg_res_s[k][SEG_W-1:0];
      nxt_c_s[k]   = seg_res_s[k][SEG_W];
    end
  end

  // Stage registers: all of them advance together or all of them hold.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      valid_r <= {STAGES{1'b0}};
      carry_r <= {STAGES{1'b0}};
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= {BIT_WIDTH{1'b0}};
        b_r[k]   <= {BIT_WIDTH{1'b0}};
        sum_r[k] <= {BIT_WIDTH{1'b0}};
      end
    end else if (adv_s) begin
      valid_r <= src_v_s;
      carry_r <= nxt_c_s;
      for (int k = 0; k < STAGES; k++) begin
        a_r[k]   <= src_a_s[k];
        b_r[k]   <= src_b_s[k];
        sum_r[k] <= nxt_sum_s[k];
      end
    end else begin
      valid_r <= valid_r;
      carry_r <= carry_r;
    end
  end

  // Outputs come straight from the last stage register.
  always_comb begin
    inReady  = adv_s;
    outValid = valid_r[LAST];
    sum      = sum_r[LAST];
    cOut     = carry_r[LAST];
  end

`ifdef ADDER_PIPE_FLAGS_EN
  logic ovf_nxt_s;
  logic zero_nxt_s;
  logic ovf_r;
  logic zero_r;

  // Flags come from the last stage's operands and from the fully resolved sum.
  // b' is used, so the same overflow rule holds for both add and subtract.
  always_comb begin
    ovf_nxt_s  = (src_a_s[LAST][MSB] == src_b_s[LAST][MSB]) &&
                 (nxt_sum_s[LAST][MSB] != src_a_s[LAST][MSB]);
    zero_nxt_s = ~|nxt_sum_s[LAST];
  end

  // Flag registers share the pipeline enable, so they always match sum.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      ovf_r  <= 1'b0;
      zero_r <= 1'b0;
    end else if (adv_s) begin
      ovf_r  <= ovf_nxt_s;
      zero_r <= zero_nxt_s;
    end else begin
      ovf_r  <= ovf_r;
      zero_r <= zero_r;
    end
  end

  // Registered flag outputs
  always_comb begin
    ovf  = ovf_r;
    zero = zero_r;
  end
`endif

endmodule

// File: tb/tb_pipelined_adder.sv
// -----------------------------------------------------------------------------
// tb_pipelined_adder
//   Directed bench for pipelined_adder at BIT_WIDTH=16, STAGES=4.
//   Inputs are driven on the falling edge and outputs are sampled on the
//   falling edge. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_pipelined_adder;

  localparam int W   = 16;
  localparam int LAT = 4;

  logic          clk = 1'b0;
  logic          rstN = 1'b1;
  logic          inValid = 1'b0;
  logic          inReady;
  logic [W-1:0]  in1 = 16'h0000;
  logic [W-1:0]  in2 = 16'h0000;
  logic          cIn = 1'b0;
  logic          sub = 1'b0;
  logic          outValid;
  logic          outReady = 1'b1;
  logic [W-1:0]  sum;
  logic          cOut;
`ifdef ADDER_PIPE_FLAGS_EN
  logic          ovf;
  logic          zero;
`endif

  int errors = 0;
  int checks = 0;

  pipelined_adder #(.BIT_WIDTH(W), .STAGES(LAT)) dut (
    .clk      (clk),
    .rstN     (rstN),
    .inValid  (inValid),
    .inReady  (inReady),
    .in1      (in1),
    .in2      (in2),
    .cIn      (cIn),
    .sub      (sub),
    .outValid (outValid),
    .outReady (outReady),
    .sum      (sum),
    .cOut     (cOut)
`ifdef ADDER_PIPE_FLAGS_EN
    ,
    .ovf      (ovf),
    .zero     (zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    inValid = 1'b0;
    #2 rstN = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL reset_outValid got=%b exp=0", outValid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL reset_sum got=%h exp=0000", sum); end
    checks++; if (cOut !== 1'b0) begin errors++; $display("FAIL reset_cOut got=%b exp=0", cOut); end
`ifdef ADDER_PIPE_FLAGS_EN
    checks++; if ({ovf, zero} !== 2'b00) begin errors++; $display("FAIL reset_flags got=%b%b exp=00", ovf, zero); end
`endif
    rstN = 1'b1;
    @(negedge clk);
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL reset_inReady got=%b exp=1", inReady); end
  endtask

  // One op whose carry ripples through every segment. outValid must stay low
  // until the 4th edge and then rise.
  task automatic test_carry_chain();
    outReady = 1'b1;
    in1 = 16'hFFFF; in2 = 16'h0001; cIn = 1'b0; sub = 1'b0; inValid = 1'b1;
    for (int cyc = 1; cyc <= LAT + 2; cyc++) begin
      @(posedge clk); @(negedge clk);
      inValid = 1'b0;
      if (cyc == LAT) begin
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL chain_valid cyc%0d got=%b exp=1", cyc, outValid); end
        checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL chain_sum got=%h exp=0000", sum); end
        checks++; if (cOut !== 1'b1) begin errors++; $display("FAIL chain_cOut got=%b exp=1", cOut); end
      end else begin
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL chain_latency cyc%0d outValid=%b exp=0", cyc, outValid); end
      end
    end
  endtask

  // Two back-to-back subtracts. The first one has cIn=1, which sub must ignore.
  task automatic test_sub();
    logic [W-1:0] a_v [2] = '{16'h0005, 16'h1234};
    logic [W-1:0] b_v [2] = '{16'h0007, 16'h1234};
    logic [W-1:0] s_v [2] = '{16'hFFFE, 16'h0000};
    logic         c_v [2] = '{1'b0, 1'b1};
    logic         z_v [2] = '{1'b0, 1'b1};
    int idx;
    outReady = 1'b1;
    in1 = a_v[0]; in2 = b_v[0]; cIn = 1'b1; sub = 1'b1; inValid = 1'b1;
    for (int cyc = 1; cyc <= 2 + LAT + 1; cyc++) begin
      @(posedge clk); @(negedge clk);
      idx = cyc - LAT;
      if (idx >= 0 && idx < 2) begin
        checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL sub%0d_valid got=%b exp=1", idx, outValid); end
        checks++; if (sum !== s_v[idx]) begin errors++; $display("FAIL sub%0d_sum got=%h exp=%h", idx, sum, s_v[idx]); end
        checks++; if (cOut !== c_v[idx]) begin errors++; $display("FAIL sub%0d_cOut got=%b exp=%b", idx, cOut, c_v[idx]); end
`ifdef ADDER_PIPE_FLAGS_EN
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL sub%0d_ovf got=%b exp=0", idx, ovf); end
        checks++; if (zero !== z_v[idx]) begin errors++; $display("FAIL sub%0d_zero got=%b exp=%b", idx, zero, z_v[idx]); end
`endif
      end else begin
        checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL sub_idle cyc%0d outValid=%b exp=0", cyc, outValid); end
      end
      if (cyc < 2) begin
        in1 = a_v[cyc]; in2 = b_v[cyc]; cIn = 1'b0; sub = 1'b1; inValid = 1'b1;
      end else begin
        inValid = 1'b0; cIn = 1'b0; sub = 1'b0;
      end
    end
  endtask

  // Streams with outReady=1, so accept and drain happen together every cycle.
  // Slot 4 is a bubble, which must come out as an outValid=0 slot.
  task automatic test_back_to_back();
    localparam int N = 9;
    logic [W-1:0] a_v [N] = '{16'h0001, 16'h00FF, 16'h0FFF, 16'h7FFF, 16'h0000,
                              16'h1234, 16'h8000, 16'h0000, 16'h8000};
    logic [W-1:0] b_v [N] = '{16'h0001, 16'h0001, 16'h0001, 16'h0001, 16'h0000,
                              16'h4321, 16'h8000, 16'h0001, 16'h0001};
    logic         ci_v[N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic         sb_v[N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic         vl_v[N] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    logic [W-1:0] s_v [N] = '{16'h0002, 16'h0100, 16'h1000, 16'h8000, 16'h0000,
                              16'h5556, 16'h0000, 16'hFFFF, 16'h7FFF};
    logic         co_v[N] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         ov_v[N] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
    logic         exp_v;
    int idx;
    outReady = 1'b1;
    in1 = a_v[0]; in2 = b_v[0]; cIn = ci_v[0]; sub = sb_v[0]; inValid = vl_v[0];
    for (int cyc = 1; cyc <= N + LAT + 1; cyc++) begin
      @(posedge clk); @(negedge clk);
      idx   = cyc - LAT;
      exp_v = (idx >= 0 && idx < N) ? vl_v[idx] : 1'b0;
      checks++; if (outValid !== exp_v) begin errors++; $display("FAIL b2b_valid cyc%0d got=%b exp=%b", cyc, outValid, exp_v); end
      if (exp_v) begin
        checks++; if (sum !== s_v[idx]) begin errors++; $display("FAIL b2b%0d_sum got=%h exp=%h", idx, sum, s_v[idx]); end
        checks++; if (cOut !== co_v[idx]) begin errors++; $display("FAIL b2b%0d_cOut got=%b exp=%b", idx, cOut, co_v[idx]); end
`ifdef ADDER_PIPE_FLAGS_EN
        checks++; if (ovf !== ov_v[idx]) begin errors++; $display("FAIL b2b%0d_ovf got=%b exp=%b", idx, ovf, ov_v[idx]); end
        checks++; if (zero !== (s_v[idx] == 16'h0000)) begin errors++; $display("FAIL b2b%0d_zero got=%b", idx, zero); end
`endif
      end
      if (cyc < N) begin
        in1 = a_v[cyc]; in2 = b_v[cyc]; cIn = ci_v[cyc]; sub = sb_v[cyc]; inValid = vl_v[cyc];
      end else begin
        inValid = 1'b0; cIn = 1'b0; sub = 1'b0;
      end
    end
  endtask

  // Three ops are queued with outReady=0. The pipe must freeze while the first
  // result is pending, and then drain A, B, C exactly once each.
  task automatic test_backpressure();
    logic [W-1:0] a_v [3] = '{16'h0010, 16'h1000, 16'hFFFF};
    logic [W-1:0] b_v [3] = '{16'h0020, 16'h0FFF, 16'hFFFF};
    logic [W-1:0] s_v [3] = '{16'h0030, 16'h1FFF, 16'hFFFE};
    logic         c_v [3] = '{1'b0, 1'b0, 1'b1};
    outReady = 1'b0;
    cIn = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in1 = a_v[i]; in2 = b_v[i]; inValid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    inValid = 1'b0;
    @(posedge clk); @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      checks++; if (inReady !== 1'b0) begin errors++; $display("FAIL bp_inReady stall%0d got=%b exp=0", s, inReady); end
      checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL bp_hold_valid stall%0d got=%b exp=1", s, outValid); end
      checks++; if (sum !== s_v[0]) begin errors++; $display("FAIL bp_hold_sum stall%0d got=%h exp=%h", s, sum, s_v[0]); end
      checks++; if (cOut !== c_v[0]) begin errors++; $display("FAIL bp_hold_cOut stall%0d got=%b exp=%b", s, cOut, c_v[0]); end
      @(posedge clk); @(negedge clk);
    end
    outReady = 1'b1;
    for (int i = 1; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (outValid !== 1'b1) begin errors++; $display("FAIL bp_drain%0d_valid got=%b exp=1", i, outValid); end
      checks++; if (sum !== s_v[i]) begin errors++; $display("FAIL bp_drain%0d_sum got=%h exp=%h", i, sum, s_v[i]); end
      checks++; if (cOut !== c_v[i]) begin errors++; $display("FAIL bp_drain%0d_cOut got=%b exp=%b", i, cOut, c_v[i]); end
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL bp_nodup%0d outValid=%b exp=0", i, outValid); end
    end
  endtask

  // Reset with three ops in flight: the output clears at once, and none of the
  // three results reappears after release.
  task automatic test_reset_inflight();
    logic [W-1:0] a_v [3] = '{16'h0101, 16'h1111, 16'h4000};
    logic [W-1:0] b_v [3] = '{16'h0202, 16'h1111, 16'h4000};
    outReady = 1'b1;
    cIn = 1'b0; sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in1 = a_v[i]; in2 = b_v[i]; inValid = 1'b1;
      @(posedge clk); @(negedge clk);
    end
    inValid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks++; if (outValid !== 1'b1 || sum !== 16'h0303) begin errors++; $display("FAIL rst_pre_out got=%b/%h exp=1/0303", outValid, sum); end
    rstN = 1'b0;
    #1;
    checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got=%b exp=0", outValid); end
    checks++; if (sum !== 16'h0000) begin errors++; $display("FAIL rst_async_sum got=%h exp=0000", sum); end
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    @(negedge clk);
    checks++; if (inReady !== 1'b1) begin errors++; $display("FAIL rst_release_inReady got=%b exp=1", inReady); end
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); @(negedge clk);
      checks++; if (outValid !== 1'b0) begin errors++; $display("FAIL rst_ghost%0d outValid=%b sum=%h exp=0", i, outValid, sum); end
    end
  endtask

  initial begin
    test_reset();
    test_carry_chain();
    test_sub();
    test_back_to_back();
    test_backpressure();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
